// File: rtl/notch_sequencer.sv
// rtl/notch_sequencer.sv - sample-flow controller between ADC stream, notch filter core and DAC
module notch_sequencer #(
    parameter int DATA_SIZE = 24,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 adc_valid_i,
    input  logic [DATA_SIZE-1:0] adc_data_i,
    input  logic                 bypass_i,
    input  logic                 clr_stats_i,
    output logic [DATA_SIZE-1:0] flt_data_in_o,
    output logic                 flt_sample_o,
    input  logic [DATA_SIZE-1:0] flt_data_out_i,
    input  logic                 flt_done_i,
    output logic                 dac_valid_o,
    output logic [DATA_SIZE-1:0] dac_data_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     overrun_cnt_o,
    output logic [CNT_W-1:0]     timeout_cnt_o
);

    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] data_in_q, data_in_d;
    logic                 sample_q, sample_d;
    logic                 dac_valid_q, dac_valid_d;
    logic [DATA_SIZE-1:0] dac_data_q, dac_data_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]     ovr_q, ovr_d;
    logic [CNT_W-1:0]     tmo_q, tmo_d;
    logic                 ovr_inc;
    logic                 tmo_inc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            data_in_q   <= '0;
            sample_q    <= 1'b0;
            dac_valid_q <= 1'b0;
            dac_data_q  <= '0;
            timer_q     <= '0;
            ovr_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_in_q   <= data_in_d;
            sample_q    <= sample_d;
            dac_valid_q <= dac_valid_d;
            dac_data_q  <= dac_data_d;
            timer_q     <= timer_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_in_d   = data_in_q;
        sample_d    = 1'b0;
        dac_valid_d = 1'b0;
        dac_data_d  = dac_data_q;
        timer_d     = timer_q;
        ovr_inc     = 1'b0;
        tmo_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (adc_valid_i) begin
                    data_in_d = adc_data_i;
                    if (bypass_i) begin
                        dac_data_d  = adc_data_i;
                        dac_valid_d = 1'b1;
                    end else begin
                        sample_d = 1'b1;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                // a done seen here belongs to an earlier request and is dropped
                ovr_inc = adc_valid_i;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ovr_inc = adc_valid_i;
                if (flt_done_i) begin
                    dac_data_d  = flt_data_out_i;
                    dac_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    dac_data_d  = data_in_q;
                    dac_valid_d = 1'b1;
                    tmo_inc     = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ovr_d = ovr_q;
        tmo_d = tmo_q;
        if (clr_stats_i) begin
            ovr_d = '0;
            tmo_d = '0;
        end else begin
            if (ovr_inc && (ovr_q != CNT_MAX)) ovr_d = ovr_q + 1'b1;
            if (tmo_inc && (tmo_q != CNT_MAX)) tmo_d = tmo_q + 1'b1;
        end
    end

    assign flt_data_in_o = data_in_q;
    assign flt_sample_o  = sample_q;
    assign dac_valid_o   = dac_valid_q;
    assign dac_data_o    = dac_data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign overrun_cnt_o = ovr_q;
    assign timeout_cnt_o = tmo_q;

endmodule

// File: tb/tb_notch_sequencer.sv
// tb/tb_notch_sequencer.sv - self-checking bench for notch_sequencer
module tb_notch_sequencer;

    localparam int DW   = 24;
    localparam int TO   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          bypass = 1'b0;
    logic          clr_stats = 1'b0;
    logic [DW-1:0] flt_data_in;
    logic          flt_sample;
    logic [DW-1:0] flt_data_out = '0;
    logic          flt_done = 1'b0;
    logic          dac_valid;
    logic [DW-1:0] dac_data;
    logic          busy;
    logic [CW-1:0] overrun_cnt;
    logic [CW-1:0] timeout_cnt;

    always #5 clk = ~clk;

    notch_sequencer #(.DATA_SIZE(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset),
        .adc_valid_i(adc_valid), .adc_data_i(adc_data), .bypass_i(bypass),
        .clr_stats_i(clr_stats),
        .flt_data_in_o(flt_data_in), .flt_sample_o(flt_sample),
        .flt_data_out_i(flt_data_out), .flt_done_i(flt_done),
        .dac_valid_o(dac_valid), .dac_data_o(dac_data), .busy_o(busy),
        .overrun_cnt_o(overrun_cnt), .timeout_cnt_o(timeout_cnt)
    );

    int total = 0;
    int bad   = 0;

    // transaction-level model: an in-flight sample is tracked by its age in edges since capture
    bit            m_busy;
    int            m_age;
    logic [DW-1:0] m_raw, m_fdi, m_dd;
    logic          m_dv, m_fs;
    int            m_ovr, m_tmo;

    typedef struct {
        logic          av;
        logic [DW-1:0] ad;
        logic          byp;
        logic          dn;
        logic [DW-1:0] fd;
        logic          e_dv;
        logic [DW-1:0] e_dd;
        logic          e_fs;
        logic          e_busy;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_raw = '0; m_fdi = '0; m_dd = '0;
        m_dv = 0; m_fs = 0; m_ovr = 0; m_tmo = 0;
    endtask

    task automatic model_edge();
        m_dv = 0;
        if (m_busy) begin
            m_age++;
            if (adc_valid) m_ovr = (m_ovr < CMAX) ? m_ovr + 1 : CMAX;
            if (m_age >= 2 && flt_done) begin
                m_dd = flt_data_out; m_dv = 1; m_busy = 0;
            end else if (m_age == TO + 1) begin
                m_dd = m_raw; m_dv = 1; m_busy = 0;
                m_tmo = (m_tmo < CMAX) ? m_tmo + 1 : CMAX;
            end
        end else if (adc_valid) begin
            m_fdi = adc_data;
            if (bypass) begin
                m_dd = adc_data; m_dv = 1;
            end else begin
                m_raw = adc_data; m_busy = 1; m_age = 0;
            end
        end
        m_fs = m_busy && (m_age == 0);
        if (clr_stats) begin
            m_ovr = 0; m_tmo = 0;
        end
    endtask

    task automatic compare_model();
        check("dac_valid", 32'(dac_valid), 32'(m_dv));
        check("dac_data", 32'(dac_data), 32'(m_dd));
        check("flt_sample", 32'(flt_sample), 32'(m_fs));
        check("flt_data_in", 32'(flt_data_in), 32'(m_fdi));
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_tmo));
    endtask

    task automatic drive(input logic av, input logic [DW-1:0] ad, input logic byp,
                         input logic dn, input logic [DW-1:0] fd, input logic clr);
        adc_valid = av; adc_data = ad; bypass = byp;
        flt_done = dn; flt_data_out = fd; clr_stats = clr;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_dv"}, 32'(dac_valid), 32'd0);
        check({tag, "_rst_dd"}, 32'(dac_data), 32'd0);
        check({tag, "_rst_fs"}, 32'(flt_sample), 32'd0);
        check({tag, "_rst_fdi"}, 32'(flt_data_in), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_ovr"}, 32'(overrun_cnt), 32'd0);
        check({tag, "_rst_tmo"}, 32'(timeout_cnt), 32'd0);
        model_reset();
        drive(0, '0, 0, 0, '0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        #1;
        do_reset("init");

        tbl[0]  = '{1'b1, 24'h000100, 1'b0, 1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b1};
        tbl[1]  = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b0, 24'h0,      1'b0, 1'b1};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[1];
        tbl[5]  = tbl[1];
        tbl[6]  = '{1'b0, 24'h0,      1'b0, 1'b1, 24'h0000F0, 1'b1, 24'h0000F0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b0, 24'h0000F0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 24'h000001, 1'b1, 1'b0, 24'h0,      1'b1, 24'h000001, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 24'h000002, 1'b1, 1'b0, 24'h0,      1'b1, 24'h000002, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 24'h000003, 1'b1, 1'b0, 24'h0,      1'b1, 24'h000003, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b0, 24'h000003, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 24'h0,      1'b0, 1'b1, 24'h000777, 1'b0, 24'h000003, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 24'h000055, 1'b0, 1'b0, 24'h0,      1'b0, 24'h000003, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 24'h0,      1'b0, 1'b1, 24'h000999, 1'b0, 24'h000003, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b0, 24'h000003, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 24'h0,      1'b0, 1'b1, 24'h0000AA, 1'b1, 24'h0000AA, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].av, tbl[i].ad, tbl[i].byp, tbl[i].dn, tbl[i].fd, 1'b0);
            step();
            check($sformatf("tbl%0d_dv", i), 32'(dac_valid), 32'(tbl[i].e_dv));
            check($sformatf("tbl%0d_dd", i), 32'(dac_data), 32'(tbl[i].e_dd));
            check($sformatf("tbl%0d_fs", i), 32'(flt_sample), 32'(tbl[i].e_fs));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // watchdog expiry: sample passes through raw
        do_reset("wd");
        drive(1, 24'hABCDEF, 0, 0, '0, 0);
        step();
        drive(0, '0, 0, 0, '0, 0);
        n = TO + 6;
        for (int i = 1; i <= TO + 5; i++) begin
            step();
            if (dac_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        check("wd_latency", 32'(n), 32'(TO + 1));
        check("wd_data", 32'(dac_data), 32'hABCDEF);
        check("wd_tmo_cnt", 32'(timeout_cnt), 32'd1);

        // done on the expiry edge wins over the watchdog
        drive(1, 24'h111111, 0, 0, '0, 0);
        step();
        drive(0, '0, 0, 0, '0, 0);
        for (int i = 1; i <= TO; i++) step();
        drive(0, '0, 0, 1, 24'h222222, 0);
        step();
        check("wd_race_dv", 32'(dac_valid), 32'd1);
        check("wd_race_dd", 32'(dac_data), 32'h222222);
        check("wd_race_tmo", 32'(timeout_cnt), 32'd1);
        drive(0, '0, 0, 0, '0, 0);
        step();

        // overrun saturation, then clear racing an overrun
        do_reset("ovr");
        drive(1, 24'h000333, 0, 0, '0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 24'h00FFFF, 0, 0, '0, 0);
            step();
        end
        check("ovr_sat", 32'(overrun_cnt), 32'(CMAX));
        check("ovr_fdi_kept", 32'(flt_data_in), 32'h000333);
        drive(0, '0, 0, 1, 24'h000444, 0);
        step();
        check("ovr_done_dv", 32'(dac_valid), 32'd1);
        check("ovr_done_dd", 32'(dac_data), 32'h000444);
        drive(1, 24'h000005, 0, 0, '0, 0);
        step();
        drive(1, 24'h000006, 0, 0, '0, 1);
        step();
        check("ovr_clr", 32'(overrun_cnt), 32'd0);
        drive(0, '0, 0, 0, '0, 0);
        step();
        drive(0, '0, 0, 1, 24'h000007, 0);
        step();

        // reset in the middle of WAIT
        drive(0, '0, 0, 0, '0, 0);
        step();
        drive(1, 24'h123456, 0, 0, '0, 0);
        step();
        drive(0, '0, 0, 0, '0, 0);
        step();
        step();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_fdi", 32'(flt_data_in), 32'h123456);
        do_reset("mid");
        for (int i = 0; i < TO + 4; i++) step();
        drive(1, 24'h000042, 0, 0, '0, 0);
        step();
        drive(0, '0, 0, 0, '0, 0);
        step();
        step();
        drive(0, '0, 0, 1, 24'h000024, 0);
        step();
        check("post_rst_dv", 32'(dac_valid), 32'd1);
        check("post_rst_dd", 32'(dac_data), 32'h000024);
        drive(0, '0, 0, 0, '0, 0);
        step();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 2) == 0, DW'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, DW'($urandom), $urandom_range(0, 40) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
